// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the programmable serial sequence detector.
package seq_ctrl_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int LEN_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // A pattern length is usable only when it is non-zero and fits the history.
    function automatic logic len_is_legal(input logic [LEN_W-1:0] len, input int max_len);
        return (len != {LEN_W{1'b0}}) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/prog_seq_detector.sv
// Serial history, fill tracking and masked pattern compare.
// hit_o is combinational: it reflects the bit being sampled on the coming edge.
module prog_seq_detector
    import seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               shift_i,
    input  logic               x_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    output logic               hit_o
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_d;
    logic [MAX_LEN-1:0] hist_next_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;
    logic [LEN_W:0]     fill_next_s;
    logic               full_s;

    // History with the current bit shifted in, and the mask of active pattern bits.
    always_comb begin
        hist_next_s    = hist_q;
        hist_next_s[0] = x_i;
        for (int i = 1; i < MAX_LEN; i++) begin
            hist_next_s[i] = hist_q[i-1];
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len_i));
        end
    end

    // Hit requires enough bits seen (counting the current one) and a masked match.
    always_comb begin
        fill_next_s = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        full_s      = (fill_next_s >= {1'b0, len_i});
        hit_o       = shift_i && full_s &&
                      (((hist_next_s ^ pattern_i) & mask_s) == {MAX_LEN{1'b0}});
    end

    // Next history and saturating fill count.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = {MAX_LEN{1'b0}};
            fill_d = {LEN_W{1'b0}};
        end else if (shift_i) begin
            hist_d = hist_next_s;
            if (full_s) begin
                fill_d = len_i;
            end else begin
                fill_d = fill_next_s[LEN_W-1:0];
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= {MAX_LEN{1'b0}};
            fill_q <= {LEN_W{1'b0}};
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run control for the serial detector: configuration, IDLE/RUN/DONE FSM,
// saturating match counter and registered status pulses.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               x,
    output logic               busy,
    output logic               match,
    output logic               done,
    output logic [CNT_W-1:0]   match_count,
    output logic               err
);

    state_e             state_q,     state_d;
    logic [MAX_LEN-1:0] pattern_q,   pattern_d;
    logic [LEN_W-1:0]   len_q,       len_d;
    logic [CNT_W-1:0]   target_q,    target_d;
    logic               cfg_valid_q, cfg_valid_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic               busy_q,      busy_d;
    logic               match_q,     match_d;
    logic               done_q,      done_d;
    logic               err_q,       err_d;
    logic               clear_s;
    logic               shift_s;
    logic               hit_s;

    prog_seq_detector #(
        .MAX_LEN (MAX_LEN)
    ) u_det (
        .clk       (clk),
        .rst_n     (rst),
        .clear_i   (clear_s),
        .shift_i   (shift_s),
        .x_i       (x),
        .len_i     (len_q),
        .pattern_i (pattern_q),
        .hit_o     (hit_s)
    );

    // Next-state, configuration, counter and status-pulse logic.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        target_d    = target_q;
        cfg_valid_d = cfg_valid_q;
        count_d     = count_q;
        match_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        clear_s     = 1'b0;
        shift_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    if (len_is_legal(cfg_len, MAX_LEN)) begin
                        pattern_d   = cfg_pattern;
                        len_d       = cfg_len;
                        target_d    = cfg_target;
                        cfg_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    err_d = 1'b0;
                end
                // Abort outranks start here, and suppresses the no-config error too.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    if (cfg_valid_q) begin
                        state_d = ST_RUN;
                        clear_s = 1'b1;
                        count_d = {CNT_W{1'b0}};
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                shift_s = 1'b1;
                err_d   = cfg_we;
                if (hit_s) begin
                    match_d = 1'b1;
                    if (count_q == {CNT_W{1'b1}}) begin
                        count_d = count_q;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    count_d = count_q;
                end
                // A hit on the abort edge is still counted, but never raises done.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hit_s && (target_q != {CNT_W{1'b0}}) && (count_d == target_q)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                err_d   = cfg_we;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pattern_q   <= {MAX_LEN{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            target_q    <= {CNT_W{1'b0}};
            cfg_valid_q <= 1'b0;
            count_q     <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            target_q    <= target_d;
            cfg_valid_q <= cfg_valid_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            match_q     <= match_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy        = busy_q;
    assign match       = match_q;
    assign done        = done_q;
    assign err         = err_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl. Stimulus pushes the expected pulse
// events; a monitor pops and compares whenever match, done or err is high.
module tb_seq_detect_ctrl;
    import seq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we, start, abort, x;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_target;
    logic       busy, match, done, err;
    logic [7:0] match_count;

    logic       s_cfg_we, s_start, s_abort, s_x;
    logic [7:0] s_cfg_pattern;
    logic [3:0] s_cfg_len;
    logic [1:0] s_cfg_target;
    logic       s_busy, s_match, s_done, s_err;
    logic [1:0] s_match_count;

    typedef struct packed {
        logic       m;
        logic       d;
        logic       e;
        logic       b;
        logic [7:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_act;
    ev_t mon_exp;
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_target(cfg_target), .start(start), .abort(abort),
        .x(x), .busy(busy), .match(match), .done(done),
        .match_count(match_count), .err(err)
    );

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cfg_we(s_cfg_we), .cfg_pattern(s_cfg_pattern),
        .cfg_len(s_cfg_len), .cfg_target(s_cfg_target), .start(s_start), .abort(s_abort),
        .x(s_x), .busy(s_busy), .match(s_match), .done(s_done),
        .match_count(s_match_count), .err(s_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic b, input logic hit, input logic dn, input logic bsy, input logic [7:0] cnt);
        x = b;
        if (hit) exp_q.push_back({1'b1, dn, 1'b0, bsy, cnt});
        @(negedge clk);
    endtask

    task automatic push_err(input logic bsy, input logic [7:0] cnt);
        exp_q.push_back({1'b0, 1'b0, 1'b1, bsy, cnt});
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_target = t;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input string name);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check(name, {31'd0, busy}, 32'd1);
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Scoreboard monitor: every pulse the DUT shows must match the next expected event.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst && (match || done || err)) begin
                mon_act = {match, done, err, busy, match_count};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event actual=%h required=none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL event actual=%h required=%h (m,d,e,b,cnt)", mon_act, mon_exp);
                    end
                end
            end
        end
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        cfg_we = 1'b0; start = 1'b0; abort = 1'b0; x = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_target = 8'd0;
        s_cfg_we = 1'b0; s_start = 1'b0; s_abort = 1'b0; s_x = 1'b0;
        s_cfg_pattern = 8'h00; s_cfg_len = 4'd0; s_cfg_target = 2'd0;
        #1;
        check("reset_outputs", {20'd0, busy, match, done, err, match_count}, 32'd0);
        check("reset_sat_count", {30'd0, s_match_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // start before any configuration
        push_err(1'b0, 8'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("nocfg_stays_idle", {31'd0, busy}, 32'd0);
        drain("queue_nocfg");

        // overlapping count, rejected cfg_we in RUN, abort on a hit edge
        do_cfg(8'h09, 4'd4, 8'd0);
        do_start("busy_after_start");
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
        cfg_we = 1'b1; cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_target = 8'd1;
        push_err(1'b1, 8'd1);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        cfg_we = 1'b0;
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check("target0_busy_held", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        send(1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        abort = 1'b0;
        check("abort_count_held", {24'd0, match_count}, 32'd3);
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {31'd0, busy}, 32'd0);
        check("idle_count_held", {24'd0, match_count}, 32'd3);
        drain("queue_overlap");

        // target reached on the second match
        do_cfg(8'h09, 4'd4, 8'd2);
        do_start("busy_target_run");
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 8'd2);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("target_idle_busy", {31'd0, busy}, 32'd0);
        check("target_count", {24'd0, match_count}, 32'd2);
        drain("queue_target");

        // single-bit pattern
        do_cfg(8'h01, 4'd1, 8'd0);
        x = 1'b1;
        @(negedge clk);
        do_start("busy_short_run");
        check("no_match_before_bit", {31'd0, match}, 32'd0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
        send(1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
        check("short_count", {24'd0, match_count}, 32'd3);
        abort = 1'b1;
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        abort = 1'b0;
        check("short_abort_idle", {31'd0, busy}, 32'd0);
        drain("queue_short");

        // illegal lengths keep the previous configuration
        cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd0; cfg_target = 8'd5;
        push_err(1'b0, 8'd3);
        @(negedge clk);
        cfg_len = 4'd9;
        push_err(1'b0, 8'd3);
        @(negedge clk);
        cfg_we = 1'b0;
        do_start("busy_after_bad_cfg");
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
        abort = 1'b1;
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        abort = 1'b0;
        drain("queue_badcfg");

        // reset in the middle of a run
        do_cfg(8'h09, 4'd4, 8'd0);
        do_start("busy_before_reset");
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
        x = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("reset_midrun_outputs", {20'd0, busy, match, done, err, match_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        push_err(1'b0, 8'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("reset_needs_cfg", {31'd0, busy}, 32'd0);
        drain("queue_reset");

        // counter saturation on a 2-bit instance
        s_cfg_we = 1'b1; s_cfg_pattern = 8'h01; s_cfg_len = 4'd1; s_cfg_target = 2'd0;
        @(negedge clk);
        s_cfg_we = 1'b0;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_x = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sat_match", {31'd0, s_match}, 32'd1);
            check("sat_count", {30'd0, s_match_count}, (i < 3) ? (i + 1) : 3);
        end
        s_x = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
